// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel programmable clock divider.
// Output mode encodings and power-on defaults used by every channel.
package clk_div_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int CNT_W_DEF        = 32;
    localparam int DEFAULT_HALF_DEF = 2500;

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi; channel i uses bit i and half_period[i*CNT_W +: CNT_W].
// Handshake: load[i] is a single-cycle strobe sampled on the rising clk edge, no back-pressure; tick[i] is a one-cycle strobe.
interface clk_div_multi_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);

    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       mode;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*CNT_W-1:0] half_period;
    logic [NUM_CH-1:0]       div_clk;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       pending;

    modport master (
        output en, mode, load, half_period,
        input  div_clk, tick, pending
    );

    modport slave (
        input  en, mode, load, half_period,
        output div_clk, tick, pending
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow terminal count and registered outputs.
// A new terminal count is applied only at terminal or while disabled, so active never drops below count.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [CNT_W-1:0] half_period,
    output logic             div_clk,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic             pulse_q;
    logic             terminal;

    assign terminal = (count == active);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            active  <= CNT_W'(DEFAULT_HALF);
            shadow  <= '0;
            pending <= 1'b0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
            pulse_q <= 1'b0;
        end else if (!en) begin
            count   <= '0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
            pulse_q <= 1'b0;
            pending <= 1'b0;
            if (load) begin
                active <= half_period;
                shadow <= half_period;
            end else if (pending) begin
                active <= shadow;
            end
        end else if (terminal) begin
            count   <= '0;
            tick    <= 1'b1;
            pulse_q <= (mode == MODE_PULSE);
            div_clk <= (mode == MODE_PULSE) ? 1'b1 : ~div_clk;
            pending <= 1'b0;
            if (load) begin
                active <= half_period;
                shadow <= half_period;
            end else if (pending) begin
                active <= shadow;
            end
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
            // Mode is latched at terminal, so only a pulse-mode strobe is retired here.
            if (pulse_q) begin
                div_clk <= 1'b0;
            end
            if (load) begin
                shadow  <= half_period;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent clk_div_chan instances.
// The packed half_period bus is sliced per channel; channels share no state.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic           clk,
    input  logic           reset,
    clk_div_multi_if.slave bus
);

    logic [NUM_CH-1:0] div_w;
    logic [NUM_CH-1:0] tick_w;
    logic [NUM_CH-1:0] pending_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_div_chan #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .en          (bus.en[i]),
            .mode        (bus.mode[i]),
            .load        (bus.load[i]),
            .half_period (bus.half_period[i*CNT_W +: CNT_W]),
            .div_clk     (div_w[i]),
            .tick        (tick_w[i]),
            .pending     (pending_w[i])
        );
    end

    assign bus.div_clk = div_w;
    assign bus.tick    = tick_w;
    assign bus.pending = pending_w;

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Multi-channel programmable clock divider, the parametrised successor of the fixed divide-by-5002 divider. Each channel has a runtime-loadable half-period with glitch-free shadow update, a per-channel enable, a toggle or pulse output mode, and a single-cycle tick strobe. It sits between the board clock and slow consumers such as display scan, debounce and LED blink logic.

Parameters:
NUM_CH, 2, number of independent divider channels (1..8)
CNT_W, 32, counter and half-period width in bits
DEFAULT_HALF, 2500, terminal count loaded into every channel at reset

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  NUM_CH  per-channel run enable; 0 holds channel cleared
mode  input  NUM_CH  per-channel output mode: 0 = toggle (50% duty), 1 = pulse
load  input  NUM_CH  per-channel single-cycle strobe; captures new terminal count
half_period  input  NUM_CH*CNT_W  packed terminal counts; channel i at bits [i*CNT_W +: CNT_W]
div_clk  output  NUM_CH  divided clock (toggle mode) or registered tick (pulse mode)
tick  output  NUM_CH  one-cycle strobe at each terminal count
pending  output  NUM_CH  1 while a loaded value awaits application

Behaviour:
- Reset (reset=0, asynchronous): count=0, active=DEFAULT_HALF, shadow=0, pending=0, div_clk=0, tick=0 on all channels.
- Per channel i, each posedge clk with reset=1:
  - en[i]=0 (synchronous clear): count<=0, div_clk<=0, tick<=0. If pending=1, then active<=shadow and pending<=0.
  - en[i]=1 and count!=active: count<=count+1, tick<=0.
  - en[i]=1 and count==active (terminal):
    - count<=0 and tick<=1 for exactly one cycle.
    - mode=0: div_clk<=~div_clk.
    - mode=1: div_clk<=1 for this one cycle only, otherwise 0.
    - If pending=1: active<=shadow, pending<=0.
- Timing:
  - Terminal count N gives N+1 clk cycles per half period.
  - Toggle mode: output period 2(N+1).
  - Pulse mode: output period N+1.
  - N=0: toggle mode divides by 2; pulse mode holds tick high continuously.
- Load:
  - load[i]=1 captures the channel slice of half_period into shadow and sets pending<=1.
  - A second load while pending overwrites shadow (last value wins).
- Simultaneous events:
  - load coincident with terminal: the new value is written directly to active and pending stays 0. The next half period uses the new value.
  - load coincident with en=0: active<=new value directly; pending stays 0.
  - mode change mid-count takes effect at the next terminal. Switching 1->0 leaves div_clk at its current registered value.
- Counter arithmetic is unsigned CNT_W bits. count never exceeds active because the comparison is equality. If active is lowered below the current count, the counter must not run away: shadow application happens only at terminal or while disabled, so active never drops below count.
- First edge: after en rises with count=0, the first tick appears on cycle N+1 after en is sampled high.
- Channels are fully independent; there is no shared state.
- Outputs are registered with no combinational path from inputs.
- reset asserted mid-count returns the channel to the reset state immediately and asynchronously.

Decomposition:
- Shared package clk_div_pkg: MODE_TOGGLE=1'b0, MODE_PULSE=1'b1, DEFAULT_HALF default constant, CNT_W default.
- Sub-module clk_div_chan: one channel (count, active, shadow, pending, output regs).
- The top generates NUM_CH instances and slices the packed half_period bus.

Test Plan:
- Reset release, en[0]=1, mode=0, default N=2500 -> first div_clk rise 2501 cycles after en is sampled; period 5002 cycles; tick pulses every 2501 cycles.
- NUM_CH=2, ch0 N=3 toggle, ch1 N=4 pulse -> ch0 period 8 cycles at 50% duty; ch1 div_clk high 1 of every 5 cycles; no cross-channel interaction.
- ch0 running with N=9; load N=2 at count=4 -> pending=1 until terminal at count=9; following half periods are 3 cycles; pending clears on the terminal cycle.
- load N=5 in the exact terminal cycle of N=9 -> pending never asserts; next half period is 6 cycles. Two loads (7, then 4) before terminal -> 4 is applied.
- en dropped mid-count with a pending load N=1 -> next cycle count=0, div_clk=0, active=1; on re-enable, toggle period is 4 cycles.
- Drive reset low asynchronously between clock edges mid-count -> div_clk, tick and pending go to 0 immediately; active returns to 2500.
